// File: rtl/glb_read_arbiter.sv
// Round-robin arbiter for the shared GLB read port. It tracks each in-flight read's
// requester ID for GLB_LAT cycles and steers the returned data back to that requester.

module glb_read_arbiter_lane #(
  parameter int IDX_W  = 2,
  parameter int ADDR_W = 32,
  parameter int LANE   = 0
) (
  input  logic              win_vld,
  input  logic [IDX_W-1:0]  win_idx,
  input  logic              ret_vld,
  input  logic [IDX_W-1:0]  ret_id,
  input  logic [ADDR_W-1:0] addr,
  output logic              grant,
  output logic              permit,
  output logic [ADDR_W-1:0] addr_sel
);
  assign grant    = win_vld && (win_idx == IDX_W'(LANE));
  assign permit   = ret_vld && (ret_id == IDX_W'(LANE));
  assign addr_sel = grant ? addr : '0;
endmodule

module glb_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GLB_LAT = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        permit_push_o,
  output logic [DATA_W-1:0]         rdata_o,
  input  logic                      glb_ready_i,
  output logic                      glb_read_en_o,
  output logic [ADDR_W-1:0]         glb_read_addr_o,
  input  logic [DATA_W-1:0]         glb_read_data_i,
  output logic                      busy_o
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STAGES = GLB_LAT - 1;

  logic [NUM_REQ-1:0]             elig;
  logic                           win_vld;
  logic [IDX_W-1:0]               win_idx;
  logic [IDX_W-1:0]               ptr;
  logic [IDX_W-1:0]               ptr_nxt;
  logic [STAGES:0]                vld_pipe;
  logic [STAGES:0][IDX_W-1:0]     id_pipe;
  logic                           ret_vld;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_sel;

  // Scan ptr, ptr+1, ... wrapping; the first eligible requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    elig    = (rst_n && glb_ready_i && !flush_i) ? req_i : '0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_vld && elig[IDX_W'(idx)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

  assign ptr_nxt = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;

  // Reset and flush both discard every in-flight read.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      ptr      <= '0;
      vld_pipe <= '0;
    end else begin
      if (win_vld) ptr <= ptr_nxt;
      vld_pipe[0] <= win_vld;
      for (int s = 1; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  always_ff @(posedge clk) begin
    id_pipe[0] <= win_idx;
    for (int s = 1; s <= STAGES; s++) id_pipe[s] <= id_pipe[s-1];
  end

  assign ret_vld = rst_n && vld_pipe[STAGES];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    glb_read_arbiter_lane #(
      .IDX_W  (IDX_W),
      .ADDR_W (ADDR_W),
      .LANE   (k)
    ) u_lane (
      .win_vld  (win_vld),
      .win_idx  (win_idx),
      .ret_vld  (ret_vld),
      .ret_id   (id_pipe[STAGES]),
      .addr     (addr_i[k*ADDR_W +: ADDR_W]),
      .grant    (grant_o[k]),
      .permit   (permit_push_o[k]),
      .addr_sel (addr_sel[k])
    );
  end

  always_comb begin
    glb_read_addr_o = '0;
    for (int k = 0; k < NUM_REQ; k++) glb_read_addr_o = glb_read_addr_o | addr_sel[k];
  end

  assign glb_read_en_o = win_vld;
  assign rdata_o       = ret_vld ? glb_read_data_i : '0;
  assign busy_o        = rst_n && ((|req_i) || (|vld_pipe));
endmodule

// File: tb/tb_glb_read_arbiter.sv
// Directed bench: two arbiters (GLB_LAT=1 and GLB_LAT=3) share one stimulus set.
module tb_glb_read_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [3:0]   req;
  logic [127:0] addr;
  logic         ready;
  logic [31:0]  gdata;

  logic [3:0]  g1, p1, g3, p3;
  logic [31:0] rd1, rd3, ad1, ad3;
  logic        en1, en3, b1, b3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  glb_read_arbiter #(.NUM_REQ(4), .GLB_LAT(1), .ADDR_W(32), .DATA_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .req_i(req), .addr_i(addr),
    .grant_o(g1), .permit_push_o(p1), .rdata_o(rd1), .glb_ready_i(ready),
    .glb_read_en_o(en1), .glb_read_addr_o(ad1), .glb_read_data_i(gdata), .busy_o(b1));

  glb_read_arbiter #(.NUM_REQ(4), .GLB_LAT(3), .ADDR_W(32), .DATA_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .req_i(req), .addr_i(addr),
    .grant_o(g3), .permit_push_o(p3), .rdata_o(rd3), .glb_ready_i(ready),
    .glb_read_en_o(en3), .glb_read_addr_o(ad3), .glb_read_data_i(gdata), .busy_o(b3));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    req   = 4'b0000;
    cyc();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req = 4'b1111; ready = 1'b1;
    gdata = 32'hFFFF_FFFF; addr = {4{32'h1111_1111}};
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if ({g1, en1, p1, b1} !== 10'd0)
        begin errors++; $display("FAIL reset_ctl1 cyc%0d: got %b want 0", c, {g1, en1, p1, b1}); end
      checks++;
      if ({ad1, rd1} !== 64'd0)
        begin errors++; $display("FAIL reset_data1 cyc%0d: got %h want 0", c, {ad1, rd1}); end
      checks++;
      if ({g3, en3, p3, b3, ad3, rd3} !== 74'd0)
        begin errors++; $display("FAIL reset_all3 cyc%0d: got %h want 0", c, {g3, en3, p3, b3, ad3, rd3}); end
      cyc();
    end
    rst_n = 1'b1; req = 4'b0000;
    cyc();
  endtask

  task automatic test_single();
    idle_flush();
    addr = '0; addr[2*32 +: 32] = 32'h1000; req = 4'b0100; gdata = 32'h0;
    #2;
    checks++;
    if (g1 !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", g1); end
    checks++;
    if (en1 !== 1'b1) begin errors++; $display("FAIL single_en: got %b want 1", en1); end
    checks++;
    if (ad1 !== 32'h1000) begin errors++; $display("FAIL single_addr: got %h want 1000", ad1); end
    cyc();
    req = 4'b0000; gdata = 32'hCAFE_BABE;
    #2;
    checks++;
    if (p1 !== 4'b0100) begin errors++; $display("FAIL single_permit: got %b want 0100", p1); end
    checks++;
    if (rd1 !== 32'hCAFE_BABE) begin errors++; $display("FAIL single_rdata: got %h want cafebabe", rd1); end
    checks++;
    if (g1 !== 4'b0000) begin errors++; $display("FAIL single_nogrant: got %b want 0000", g1); end
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", b1); end
    cyc();
  endtask

  task automatic test_contention();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] eg, ep;
    idle_flush();
    addr = {32'h400, 32'h300, 32'h200, 32'h100};
    for (int i = 0; i < 7; i++) begin
      req = (i < 6) ? 4'b1111 : 4'b0000;
      eg  = (i < 6) ? 4'(1 << seq[i]) : 4'b0000;
      ep  = (i > 0) ? 4'(1 << seq[i-1]) : 4'b0000;
      #2;
      checks++;
      if (g1 !== eg) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, g1, eg); end
      checks++;
      if (p1 !== ep) begin errors++; $display("FAIL rr_permit[%0d]: got %b want %b", i, p1, ep); end
      if (i < 6) begin
        checks++;
        if (ad1 !== 32'(32'h100 * (seq[i] + 1)))
          begin errors++; $display("FAIL rr_addr[%0d]: got %h want %h", i, ad1, 32'h100 * (seq[i] + 1)); end
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    req = 4'b1010; ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if ({g1, en1} !== 5'd0) begin errors++; $display("FAIL bp_nogrant[%0d]: got %b want 0", c, {g1, en1}); end
      checks++;
      if (b1 !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b want 1", c, b1); end
      checks++;
      if (p1 !== 4'b0000) begin errors++; $display("FAIL bp_permit[%0d]: got %b want 0000", c, p1); end
      cyc();
    end
    ready = 1'b1;
    #2;
    checks++;
    if (g1 !== 4'b1000) begin errors++; $display("FAIL bp_grant3: got %b want 1000", g1); end
    checks++;
    if (ad1 !== 32'h400) begin errors++; $display("FAIL bp_addr3: got %h want 400", ad1); end
    cyc();
    #2;
    checks++;
    if (g1 !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b want 0010", g1); end
    checks++;
    if (p1 !== 4'b1000) begin errors++; $display("FAIL bp_permit3: got %b want 1000", p1); end
    cyc();
    req = 4'b0000;
    #2;
    checks++;
    if (p1 !== 4'b0010) begin errors++; $display("FAIL bp_permit1: got %b want 0010", p1); end
    cyc();
  endtask

  task automatic test_flush();
    idle_flush();
    req = 4'b0001;
    #2;
    checks++;
    if (g3 !== 4'b0001) begin errors++; $display("FAIL fl_grant0: got %b want 0001", g3); end
    cyc();
    req = 4'b0100; flush = 1'b1;
    #2;
    checks++;
    if ({g3, en3} !== 5'd0) begin errors++; $display("FAIL fl_nogrant: got %b want 0", {g3, en3}); end
    checks++;
    if (p1 !== 4'b0001) begin errors++; $display("FAIL fl_due_permit: got %b want 0001", p1); end
    cyc();
    flush = 1'b0; req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      #2;
      checks++;
      if (p3 !== 4'b0000) begin errors++; $display("FAIL fl_suppressed[%0d]: got %b want 0000", c, p3); end
      checks++;
      if (b3 !== 1'b0) begin errors++; $display("FAIL fl_busy[%0d]: got %b want 0", c, b3); end
      cyc();
    end
    req = 4'b1111;
    #2;
    checks++;
    if (g3 !== 4'b0001) begin errors++; $display("FAIL fl_ptr_zero: got %b want 0001", g3); end
    cyc();
    req = 4'b0000;
    repeat (4) cyc();
  endtask

  task automatic test_back_to_back();
    logic [3:0]  eg, ep;
    logic [31:0] ed;
    idle_flush();
    addr = '0;
    for (int i = 0; i < 10; i++) begin
      req = (i < 6) ? 4'b0010 : 4'b0000;
      if (i < 6) addr[32 +: 32] = 32'h1000 + 32'(4 * i);
      eg = (i < 6) ? 4'b0010 : 4'b0000;
      ep = (i >= 3 && i < 9) ? 4'b0010 : 4'b0000;
      ed = 32'hD000_0000 + 32'(i - 3);
      gdata = (i >= 3 && i < 9) ? ed : 32'hDEAD_0000;
      #2;
      checks++;
      if (g3 !== eg) begin errors++; $display("FAIL b2b_grant[%0d]: got %b want %b", i, g3, eg); end
      if (i < 6) begin
        checks++;
        if (ad3 !== 32'h1000 + 32'(4 * i))
          begin errors++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, ad3, 32'h1000 + 32'(4 * i)); end
      end
      checks++;
      if (p3 !== ep) begin errors++; $display("FAIL b2b_permit[%0d]: got %b want %b", i, p3, ep); end
      checks++;
      if (rd3 !== ((ep != 4'b0000) ? ed : 32'h0))
        begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, rd3, (ep != 4'b0000) ? ed : 32'h0); end
      cyc();
    end
  endtask

  task automatic test_mid_reset();
    idle_flush();
    req = 4'b0001;
    #2;
    checks++;
    if (g3 !== 4'b0001) begin errors++; $display("FAIL mr_grant: got %b want 0001", g3); end
    cyc();
    rst_n = 1'b0; req = 4'b0000;
    #2;
    checks++;
    if ({g3, p3, b3} !== 9'd0) begin errors++; $display("FAIL mr_forced: got %b want 0", {g3, p3, b3}); end
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if ({p3, b3} !== 5'd0) begin errors++; $display("FAIL mr_discard[%0d]: got %b want 0", c, {p3, b3}); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
